// File: rtl/kitt_pkg.sv
// Shared KITT scanner definitions: shifter FSM state encoding and default LED-chain geometry.
// No logic, so no latency.
// No handshake.
package kitt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        LATCH = 2'd3
    } kitt_state_t;

    localparam int KITT_WIDTH   = 8;
    localparam int KITT_CLK_DIV = 2;

endpackage

// File: rtl/kitt_tick_div.sv
// Loadable down-counter: one-cycle o_tick in the CLK_DIV-th cycle after i_load, then stays quiet.
// Latency is CLK_DIV cycles from load to tick.
// No backpressure; a load at any time restarts the count.
module kitt_tick_div #(
    parameter int CLK_DIV = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    output logic o_tick
);

    localparam int            CW     = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_armed;

    // r_armed keeps the tick single-cycle once the count has run out.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_armed <= 1'b0;
        end else if (i_load) begin
            r_cnt   <= RELOAD;
            r_armed <= 1'b1;
        end else if (o_tick) begin
            r_armed <= 1'b0;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tick = r_armed && (r_cnt == '0);

endmodule

// File: rtl/kitt_led_shifter.sv
// Serial 74HC595 driver: shifts one WIDTH-bit pattern out on SER/SRCLK, then pulses RCLK.
// Accept to idle is 1+(2*WIDTH+1)*CLK_DIV cycles; SER valid the cycle after accept.
// pat_ready only in IDLE with ena high; offers during a transfer are ignored, no queueing.
module kitt_led_shifter
    import kitt_pkg::*;
#(
    parameter int WIDTH     = KITT_WIDTH,
    parameter int CLK_DIV   = KITT_CLK_DIV,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] pat_data,
    input  logic             pat_valid,
    output logic             pat_ready,
    output logic             ser_out,
    output logic             srclk,
    output logic             rclk,
    output logic             busy
);

    localparam int BW = $clog2(WIDTH);

    kitt_state_t      r_state;
    logic [WIDTH-1:0] r_shift;
    logic [BW-1:0]    r_bitcnt;
    logic             r_ser;
    logic             r_srclk;
    logic             r_rclk;
    logic             r_busy;

    logic             w_accept;
    logic             w_tick;
    logic             w_load;
    logic [WIDTH-1:0] w_shifted;

    function automatic logic head_bit(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
    endfunction

    assign pat_ready = ena && (r_state == IDLE);
    assign w_accept  = pat_valid && pat_ready;
    assign w_shifted = (MSB_FIRST != 0) ? {r_shift[WIDTH-2:0], 1'b0}
                                        : {1'b0, r_shift[WIDTH-1:1]};

    // Reload the divider on every state entry except the return to IDLE.
    assign w_load = w_accept || (w_tick && ((r_state == SETUP) || (r_state == HIGH)));

    kitt_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_div (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_load  (w_load),
        .o_tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_ser    <= 1'b0;
            r_srclk  <= 1'b0;
            r_rclk   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shift  <= pat_data;
                        r_bitcnt <= BW'(WIDTH - 1);
                        r_ser    <= head_bit(pat_data);
                        r_srclk  <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= SETUP;
                    end
                end
                SETUP: begin
                    if (w_tick) begin
                        r_srclk <= 1'b1;
                        r_state <= HIGH;
                    end
                end
                HIGH: begin
                    if (w_tick) begin
                        r_srclk <= 1'b0;
                        if (r_bitcnt == '0) begin
                            r_ser   <= 1'b0;
                            r_rclk  <= 1'b1;
                            r_state <= LATCH;
                        end else begin
                            r_shift  <= w_shifted;
                            r_ser    <= head_bit(w_shifted);
                            r_bitcnt <= r_bitcnt - 1'b1;
                            r_state  <= SETUP;
                        end
                    end
                end
                LATCH: begin
                    if (w_tick) begin
                        r_rclk  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ser_out = r_ser;
    assign srclk   = r_srclk;
    assign rclk    = r_rclk;
    assign busy    = r_busy;

endmodule

// File: tb/tb_kitt_led_shifter.sv
// Bench for kitt_led_shifter: two instances (MSB-first CLK_DIV=2, LSB-first CLK_DIV=1) feeding
// behavioural 595 models; directed vector table plus hand-written multi-cycle sequences.
module tb_kitt_led_shifter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       ena_a, valid_a, ready_a, ser_a, srclk_a, rclk_a, busy_a;
    logic [7:0] data_a;
    logic       ena_b, valid_b, ready_b, ser_b, srclk_b, rclk_b, busy_b;
    logic [7:0] data_b;

    kitt_led_shifter #(.WIDTH(8), .CLK_DIV(2), .MSB_FIRST(1)) u_a (
        .clk(clk), .rst_n(rst_n), .ena(ena_a), .pat_data(data_a), .pat_valid(valid_a),
        .pat_ready(ready_a), .ser_out(ser_a), .srclk(srclk_a), .rclk(rclk_a), .busy(busy_a)
    );

    kitt_led_shifter #(.WIDTH(8), .CLK_DIV(1), .MSB_FIRST(0)) u_b (
        .clk(clk), .rst_n(rst_n), .ena(ena_b), .pat_data(data_b), .pat_valid(valid_b),
        .pat_ready(ready_b), .ser_out(ser_b), .srclk(srclk_b), .rclk(rclk_b), .busy(busy_b)
    );

    int total = 0;
    int bad   = 0;

    // Cycle counter and accept monitor share one block so they read the same pre-edge values.
    int cyc = 0;
    int acc_a = 0, last_acc_a = 0, acc_gap_a = 0;
    int acc_b = 0;
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (valid_a && ready_a) begin
            acc_a      = acc_a + 1;
            acc_gap_a  = cyc - last_acc_a;
            last_acc_a = cyc;
        end
        if (valid_b && ready_b) acc_b = acc_b + 1;
    end

    // 595 models. bits_x records sampled SER values, first sample ending up in the MSB.
    logic [7:0] sr_a = '0, latch_a = '0, bits_a = '0;
    logic [7:0] sr_b = '0, latch_b = '0, bits_b = '0;
    int rises_a = 0, pulses_a = 0, rhi_a = 0, last_fall_a = 0, gap_a = 0;
    int rises_b = 0, pulses_b = 0, rhi_b = 0;

    always @(posedge srclk_a) begin
        sr_a    = {sr_a[6:0], ser_a};
        bits_a  = {bits_a[6:0], ser_a};
        rises_a = rises_a + 1;
        gap_a   = cyc - last_fall_a;
    end
    always @(negedge srclk_a) last_fall_a = cyc;
    always @(posedge rclk_a) begin
        latch_a  = sr_a;
        pulses_a = pulses_a + 1;
    end

    always @(posedge srclk_b) begin
        sr_b    = {ser_b, sr_b[7:1]};
        bits_b  = {bits_b[6:0], ser_b};
        rises_b = rises_b + 1;
    end
    always @(posedge rclk_b) begin
        latch_b  = sr_b;
        pulses_b = pulses_b + 1;
    end

    always @(negedge clk) begin
        if (rclk_a === 1'b1) rhi_a = rhi_a + 1;
        if (rclk_b === 1'b1) rhi_b = rhi_b + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Offer one pattern for one cycle, then wait (bounded) for pat_ready to return.
    // lat counts clock edges from the accept edge (inclusive) to pat_ready high.
    task automatic send(input bit b, input logic [7:0] d, output int lat);
        @(negedge clk);
        chk("ready_before_send", b ? ready_b : ready_a, 1);
        if (b) begin valid_b = 1'b1; data_b = d; end
        else   begin valid_a = 1'b1; data_a = d; end
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        if (b) valid_b = 1'b0; else valid_a = 1'b0;
        chk("busy_after_accept", b ? busy_b : busy_a, 1);
        chk("ser_head_bit", b ? ser_b : ser_a, b ? d[0] : d[7]);
        while (!(b ? ready_b : ready_a) && lat < 500) begin
            @(negedge clk);
            lat = lat + 1;
        end
    endtask

    typedef struct {
        logic [7:0] pat;
        logic [7:0] exp_latch;
        logic [7:0] exp_bits;
        int         exp_rises;
        int         exp_pulses;
        int         exp_rhi;
        int         exp_lat;
    } vec_t;

    vec_t vecs [3];

    initial begin
        int lat, r0, p0, h0, a0;

        // Instance A: WIDTH=8, CLK_DIV=2, MSB first -> ready 1+17*2 = 35 edges after accept.
        vecs[0] = '{8'h81, 8'h81, 8'h81, 8, 1, 2, 35};
        vecs[1] = '{8'hC3, 8'hC3, 8'hC3, 8, 1, 2, 35};
        vecs[2] = '{8'h55, 8'h55, 8'h55, 8, 1, 2, 35};

        rst_n = 1'b0;
        ena_a = 1'b1; valid_a = 1'b0; data_a = '0;
        ena_b = 1'b1; valid_b = 1'b0; data_b = '0;
        #12;
        chk("rst_ser_a",   ser_a,   0);
        chk("rst_srclk_a", srclk_a, 0);
        chk("rst_rclk_a",  rclk_a,  0);
        chk("rst_busy_a",  busy_a,  0);
        chk("rst_ready_a", ready_a, 1);
        chk("rst_ready_b", ready_b, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            r0 = rises_a; p0 = pulses_a; h0 = rhi_a;
            send(1'b0, vecs[i].pat, lat);
            chk("vec_ready_latency", lat,           vecs[i].exp_lat);
            chk("vec_latch",         latch_a,       vecs[i].exp_latch);
            chk("vec_sampled_bits",  bits_a,        vecs[i].exp_bits);
            chk("vec_srclk_rises",   rises_a - r0,  vecs[i].exp_rises);
            chk("vec_rclk_pulses",   pulses_a - p0, vecs[i].exp_pulses);
            chk("vec_rclk_high_cyc", rhi_a - h0,    vecs[i].exp_rhi);
        end

        // Back-to-back with valid held high: 0x18 then 0x3C.
        r0 = rises_a; p0 = pulses_a; a0 = acc_a;
        @(negedge clk);
        valid_a = 1'b1; data_a = 8'h18;
        for (int i = 0; i < 10 && acc_a < a0 + 1; i++) @(negedge clk);
        chk("b2b_first_accept", acc_a - a0, 1);
        data_a = 8'h3C;
        for (int i = 0; i < 100 && acc_a < a0 + 2; i++) @(negedge clk);
        valid_a = 1'b0;
        chk("b2b_second_accept",  acc_a - a0, 2);
        chk("b2b_accept_spacing", acc_gap_a, 35);
        chk("b2b_latch_first",    latch_a, 8'h18);
        for (int i = 0; i < 100 && rises_a < r0 + 9; i++) @(negedge clk);
        chk("b2b_fall_to_rise_gap", gap_a, 5);
        for (int i = 0; i < 100 && !ready_a; i++) @(negedge clk);
        chk("b2b_latch_second", latch_a, 8'h3C);
        chk("b2b_rises",        rises_a - r0, 16);
        chk("b2b_pulses",       pulses_a - p0, 2);

        // Offer 0xFF in the middle of a 0x01 transfer; it must be ignored.
        p0 = pulses_a; a0 = acc_a;
        @(negedge clk);
        valid_a = 1'b1; data_a = 8'h01;
        @(negedge clk);
        valid_a = 1'b0;
        repeat (6) @(negedge clk);
        valid_a = 1'b1; data_a = 8'hFF;
        chk("ignore_ready_low", ready_a, 0);
        repeat (3) @(negedge clk);
        valid_a = 1'b0;
        for (int i = 0; i < 100 && !ready_a; i++) @(negedge clk);
        chk("ignore_accepts", acc_a - a0, 1);
        chk("ignore_latch",   latch_a, 8'h01);
        chk("ignore_pulses",  pulses_a - p0, 1);

        // Re-latch 0x55, then reset in the middle of 0xAA.
        send(1'b0, 8'h55, lat);
        chk("pre_reset_latch", latch_a, 8'h55);
        r0 = rises_a; p0 = pulses_a;
        @(negedge clk);
        valid_a = 1'b1; data_a = 8'hAA;
        @(negedge clk);
        valid_a = 1'b0;
        for (int i = 0; i < 100 && rises_a < r0 + 4; i++) @(negedge clk);
        chk("reset_four_rises", rises_a - r0, 4);
        rst_n = 1'b0;
        #1;
        chk("midrst_ser",   ser_a,   0);
        chk("midrst_srclk", srclk_a, 0);
        chk("midrst_rclk",  rclk_a,  0);
        chk("midrst_busy",  busy_a,  0);
        chk("midrst_ready", ready_a, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("midrst_no_pulse", pulses_a - p0, 0);
        chk("midrst_latch_kept", latch_a, 8'h55);
        send(1'b0, 8'h0F, lat);
        chk("post_reset_latch", latch_a, 8'h0F);

        // Instance B: LSB first, CLK_DIV=1 -> ready 1+17 = 18 edges after accept.
        r0 = rises_b; p0 = pulses_b; h0 = rhi_b;
        send(1'b1, 8'h01, lat);
        chk("lsb_ready_latency", lat, 18);
        chk("lsb_sampled_bits",  bits_b, 8'h80);
        chk("lsb_latch",         latch_b, 8'h01);
        chk("lsb_rises",         rises_b - r0, 8);
        chk("lsb_pulses",        pulses_b - p0, 1);
        chk("lsb_rclk_high_cyc", rhi_b - h0, 1);

        // ena low blocks new accepts.
        r0 = rises_b; a0 = acc_b;
        @(negedge clk);
        ena_b = 1'b0;
        #1;
        chk("ena_low_ready", ready_b, 0);
        valid_b = 1'b1; data_b = 8'h3C;
        repeat (4) @(negedge clk);
        chk("ena_low_accepts", acc_b - a0, 0);
        chk("ena_low_busy",    busy_b, 0);
        chk("ena_low_rises",   rises_b - r0, 0);
        valid_b = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
